// File: rtl/hello_rx.sv
// hello_rx: 8N1 UART receiver feeding a fixed-message matcher.
// The receiver samples mid-bit using a baud count latched at each start
// edge. The matcher tracks progress through "Hello, World! \r\n" and
// reports a full in-order match or a per-byte mismatch.
// Optional feature: define HELLO_RX_BREAK_EN to enable line-break
// detection on o_break. When it is undefined, o_break is tied low.
module hello_rx #(
   parameter int LGMSGCOUNT = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic [29:0]           i_setup,
   input  logic                  i_uart_rx,
   output logic                  o_wr,
   output logic [7:0]            o_data,
   output logic                  o_frame_err,
   output logic                  o_match,
   output logic                  o_mismatch,
   output logic [LGMSGCOUNT-1:0] o_msg_count,
   output logic                  o_break
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t                r_state, w_next_state;
   logic                  r_rx_meta, r_rx_sync, r_rx_last;
   logic [23:0]           r_baud, r_cnt, w_setup_baud;
   logic [2:0]            r_bitcnt;
   logic [7:0]            r_shift;
   logic                  w_cnt_zero;
   logic                  w_start_det, w_reload, w_sample, w_wr_set, w_fe_set;
   logic                  r_wr, r_fe, r_match, r_mismatch;
   logic [7:0]            r_data, w_expected;
   logic [3:0]            r_index;
   logic [LGMSGCOUNT-1:0] r_msg_count;
   logic                  w_break;
   logic                  w_unused;

   // The upper setup bits carry format options that this receiver does not support.
   assign w_unused     = &{1'b0, i_setup[29:24]};
   assign w_setup_baud = (i_setup[23:0] < 24'd16) ? 24'd16 : i_setup[23:0];
   assign w_cnt_zero   = (r_cnt == '0);

   // Two-flop synchronizer plus a delayed copy for falling-edge detection.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_last <= 1'b1;
      end else begin
         r_rx_meta <= i_uart_rx;
         r_rx_sync <= r_rx_meta;
         r_rx_last <= r_rx_sync;
      end
   end

   // Receive FSM state register.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= S_IDLE;
      else            r_state <= w_next_state;
   end

   // Receive FSM next-state logic and datapath controls.
   always_comb begin
      w_next_state = r_state;
      w_start_det  = 1'b0;
      w_reload     = 1'b0;
      w_sample     = 1'b0;
      w_wr_set     = 1'b0;
      w_fe_set     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_rx_last && !r_rx_sync) begin
               w_start_det  = 1'b1;
               w_next_state = S_START;
            end
         end
         S_START: begin
            if (w_cnt_zero) begin
               if (!r_rx_sync) begin
                  w_reload     = 1'b1;
                  w_next_state = S_DATA;
               end else begin
                  w_next_state = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (w_cnt_zero) begin
               w_sample = 1'b1;
               w_reload = 1'b1;
               if (r_bitcnt == 3'd7) w_next_state = S_STOP;
            end
         end
         S_STOP: begin
            if (w_cnt_zero) begin
               if (r_rx_sync) begin
                  w_wr_set     = !w_break;
                  w_next_state = S_IDLE;
               end else begin
                  w_fe_set     = 1'b1;
                  w_next_state = S_WAIT_HIGH;
               end
            end
         end
         S_WAIT_HIGH: begin
            if (r_rx_sync) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Baud counter, latched baud value, bit counter and shift register.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_baud   <= 24'd16;
         r_cnt    <= '0;
         r_bitcnt <= '0;
         r_shift  <= '0;
      end else begin
         if (w_start_det) begin
            r_baud   <= w_setup_baud;
            r_cnt    <= w_setup_baud >> 1;
            r_bitcnt <= '0;
         end else if (w_reload) begin
            r_cnt <= r_baud - 24'd1;
         end else if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 24'd1;
         end
         if (w_sample) begin
            r_shift  <= {r_rx_sync, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
         end
      end
   end

   // Registered receive strobes and held output byte.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr   <= 1'b0;
         r_fe   <= 1'b0;
         r_data <= '0;
      end else begin
         r_wr <= w_wr_set;
         r_fe <= w_fe_set;
         if (w_wr_set) r_data <= r_shift;
      end
   end

   // Expected message byte at the current match index.
   always_comb begin
      w_expected = 8'h00;
      case (r_index)
         4'd0:  w_expected = 8'h48; // H
         4'd1:  w_expected = 8'h65; // e
         4'd2:  w_expected = 8'h6C; // l
         4'd3:  w_expected = 8'h6C; // l
         4'd4:  w_expected = 8'h6F; // o
         4'd5:  w_expected = 8'h2C; // ,
         4'd6:  w_expected = 8'h20; // space
         4'd7:  w_expected = 8'h57; // W
         4'd8:  w_expected = 8'h6F; // o
         4'd9:  w_expected = 8'h72; // r
         4'd10: w_expected = 8'h6C; // l
         4'd11: w_expected = 8'h64; // d
         4'd12: w_expected = 8'h21; // !
         4'd13: w_expected = 8'h20; // space
         4'd14: w_expected = 8'h0D; // \r
         4'd15: w_expected = 8'h0A; // \n
         default: w_expected = 8'h00;
      endcase
   end

   // Message matcher: advances on matching bytes, resyncs on mismatches.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_index     <= '0;
         r_match     <= 1'b0;
         r_mismatch  <= 1'b0;
         r_msg_count <= '0;
      end else begin
         r_match    <= 1'b0;
         r_mismatch <= 1'b0;
         if (w_break || r_fe) begin
            r_index <= '0;
         end else if (r_wr) begin
            if (r_data == w_expected) begin
               if (r_index == 4'd15) begin
                  r_match     <= 1'b1;
                  r_msg_count <= r_msg_count + LGMSGCOUNT'(1);
                  r_index     <= '0;
               end else begin
                  r_index <= r_index + 4'd1;
               end
            end else begin
               r_mismatch <= 1'b1;
               r_index    <= (r_data == 8'h48) ? 4'd1 : 4'd0;
            end
         end
      end
   end

`ifdef HELLO_RX_BREAK_EN
   logic [27:0] r_brk_cnt, w_brk_limit;
   logic        r_break;

   assign w_brk_limit = 28'(r_baud) * 28'd10;

   // Counts consecutive low samples; break is flagged beyond ten baud periods.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_brk_cnt <= '0;
         r_break   <= 1'b0;
      end else if (r_rx_sync) begin
         r_brk_cnt <= '0;
         r_break   <= 1'b0;
      end else begin
         if (r_brk_cnt != '1) r_brk_cnt <= r_brk_cnt + 28'd1;
         if (r_brk_cnt >= w_brk_limit) r_break <= 1'b1;
      end
   end

   assign w_break = r_break;
`else
   assign w_break = 1'b0;
`endif

   assign o_wr        = r_wr;
   assign o_data      = r_data;
   assign o_frame_err = r_fe;
   assign o_match     = r_match;
   assign o_mismatch  = r_mismatch;
   assign o_msg_count = r_msg_count;
   assign o_break     = w_break;

endmodule

// File: tb/tb_hello_rx.sv
// Directed bench for hello_rx: table of serial bytes with expected strobes,
// plus hand-written sequences for reset, glitch and long-low cases.
module tb_hello_rx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [29:0] setup;
   logic        rx;
   logic        o_wr, o_frame_err, o_match, o_mismatch, o_break;
   logic [7:0]  o_data;
   logic [15:0] o_msg_count;

   hello_rx #(.LGMSGCOUNT(16)) dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_setup     (setup),
      .i_uart_rx   (rx),
      .o_wr        (o_wr),
      .o_data      (o_data),
      .o_frame_err (o_frame_err),
      .o_match     (o_match),
      .o_mismatch  (o_mismatch),
      .o_msg_count (o_msg_count),
      .o_break     (o_break)
   );

   always #5 clk = ~clk;

`ifdef HELLO_RX_BREAK_EN
   localparam bit BRK_EXP = 1'b1;
`else
   localparam bit BRK_EXP = 1'b0;
`endif

   typedef struct {
      logic [29:0] setup;
      logic [7:0]  b;
      bit          stop_ok;
      bit          chg;
      bit          e_wr;
      logic [7:0]  e_data;
      bit          e_fe;
      bit          e_match;
      bit          e_mis;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] last_data = 8'h00;
   int         n_chk = 0, n_pass = 0;
   int         n_wr = 0, n_fe = 0, n_match = 0, n_mis = 0, n_both = 0;

   // Strobe monitor sampled on the falling edge.
   always @(negedge clk) begin
      if (o_wr)                  n_wr++;
      if (o_frame_err)           n_fe++;
      if (o_match)               n_match++;
      if (o_mismatch)            n_mis++;
      if (o_match && o_mismatch) n_both++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic void add(input logic [29:0] s, input logic [7:0] b, input bit ok,
                               input bit chg, input bit fe, input bit m, input bit mis);
      vec_t v;
      v.setup = s; v.b = b; v.stop_ok = ok; v.chg = chg;
      v.e_wr = ok; v.e_fe = fe; v.e_match = m; v.e_mis = mis;
      if (ok) last_data = b;
      v.e_data = last_data;
      vecs.push_back(v);
   endfunction

   function automatic void add_str(input string s, input logic [29:0] su,
                                   input int mis_pos, input bit match_last);
      for (int i = 0; i < s.len(); i++)
         add(su, s[i], 1'b1, 1'b0, 1'b0, match_last && (i == s.len() - 1), i == mis_pos);
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit ok, input bit chg,
                            input logic [29:0] su, input int baud);
      setup = su;
      rx = 1'b0;
      repeat (baud) @(negedge clk);
      if (chg) setup = 30'd40;
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (baud) @(negedge clk);
      end
      rx = ok;
      repeat (baud) @(negedge clk);
      rx = 1'b1;
      setup = su;
      repeat (10) @(negedge clk);
   endtask

   task automatic send_str(input string s, input logic [29:0] su, input int baud);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1, 1'b0, su, baud);
   endtask

   initial begin
      string msg;
      int    s_wr, s_fe, s_match, s_mis;
      msg   = "Hello, World! \r\n";
      rst_n = 1'b0;
      rx    = 1'b1;
      setup = 30'd16;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst o_wr",        32'(o_wr),        0);
      check("rst o_data",      32'(o_data),      0);
      check("rst o_frame_err", 32'(o_frame_err), 0);
      check("rst o_match",     32'(o_match),     0);
      check("rst o_mismatch",  32'(o_mismatch),  0);
      check("rst o_msg_count", 32'(o_msg_count), 0);
      check("rst o_break",     32'(o_break),     0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Vector table
      add_str(msg, 30'd16, -1, 1'b1);
      add_str(msg, {6'h2A, 24'd16}, -1, 1'b1);          // upper setup bits ignored
      add_str("HeX", 30'd16, 2, 1'b0);
      add_str(msg, 30'd16, -1, 1'b1);
      add_str("HH", 30'd5, 1, 1'b0);                    // baud below 16 clamps to 16
      add_str("ello, World! \r\n", 30'd5, -1, 1'b1);
      add_str("He", 30'd16, -1, 1'b0);
      add(30'd16, 8'h48, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // stop bit low
      add(30'd16, 8'h48, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // setup changed mid-frame
      add_str("ello, World! \r\n", 30'd16, -1, 1'b1);

      for (int i = 0; i < vecs.size(); i++) begin
         s_wr = n_wr; s_fe = n_fe; s_match = n_match; s_mis = n_mis;
         send_byte(vecs[i].b, vecs[i].stop_ok, vecs[i].chg, vecs[i].setup, 16);
         check($sformatf("v%0d wr", i),    32'(n_wr - s_wr),       32'(vecs[i].e_wr));
         check($sformatf("v%0d data", i),  32'(o_data),            32'(vecs[i].e_data));
         check($sformatf("v%0d fe", i),    32'(n_fe - s_fe),       32'(vecs[i].e_fe));
         check($sformatf("v%0d match", i), 32'(n_match - s_match), 32'(vecs[i].e_match));
         check($sformatf("v%0d mis", i),   32'(n_mis - s_mis),     32'(vecs[i].e_mis));
      end
      check("table msg_count", 32'(o_msg_count), 5);

      // Reset in the middle of a byte, then a full message
      setup = 30'd16;
      rx = 1'b0;
      repeat (16 * 5) @(negedge clk);
      rst_n = 1'b0;
      rx = 1'b1;
      @(negedge clk);
      check("midrst o_data",      32'(o_data),      0);
      check("midrst o_msg_count", 32'(o_msg_count), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      s_wr = n_wr; s_fe = n_fe; s_match = n_match; s_mis = n_mis;
      send_str(msg, 30'd16, 16);
      check("midrst wr",        32'(n_wr - s_wr),       16);
      check("midrst fe",        32'(n_fe - s_fe),       0);
      check("midrst match",     32'(n_match - s_match), 1);
      check("midrst mis",       32'(n_mis - s_mis),     0);
      check("midrst msg_count", 32'(o_msg_count),       1);

      // 300-clock glitch at 868 clocks per baud, then a real byte at that rate
      setup = 30'd868;
      s_wr = n_wr; s_fe = n_fe; s_match = n_match; s_mis = n_mis;
      rx = 1'b0;
      repeat (300) @(negedge clk);
      rx = 1'b1;
      repeat (1000) @(negedge clk);
      check("glitch strobes", 32'((n_wr - s_wr) + (n_fe - s_fe) + (n_match - s_match) + (n_mis - s_mis)), 0);
      send_byte(8'h48, 1'b1, 1'b0, 30'd868, 868);
      check("b868 wr",   32'(n_wr - s_wr),   1);
      check("b868 data", 32'(o_data),        32'h48);
      check("b868 mis",  32'(n_mis - s_mis), 0);

      // Line held low for 12 baud periods
      setup = 30'd16;
      s_wr = n_wr; s_fe = n_fe; s_mis = n_mis;
      rx = 1'b0;
      repeat (16 * 9) @(negedge clk);
      check("brk early", 32'(o_break), 0);
      repeat (16 * 3) @(negedge clk);
      check("brk set",  32'(o_break),     32'(BRK_EXP));
      check("brk wr",   32'(n_wr - s_wr),   0);
      check("brk fe",   32'(n_fe - s_fe),   1);
      check("brk mis",  32'(n_mis - s_mis), 0);
      rx = 1'b1;
      repeat (4) @(negedge clk);
      check("brk clear", 32'(o_break), 0);
      repeat (16) @(negedge clk);

      // Index must be back at 0: a full message matches cleanly
      s_match = n_match; s_mis = n_mis;
      send_str(msg, 30'd16, 16);
      check("post match",     32'(n_match - s_match), 1);
      check("post mis",       32'(n_mis - s_mis),     0);
      check("post msg_count", 32'(o_msg_count),       2);
      check("match&mismatch", 32'(n_both),            0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/hello_rx.md
HELLO_RX -- requirements
Module: hello_rx

Interface
REQ-001 Parameter LGMSGCOUNT, default 16: width of the matched-message counter.
REQ-002 i_clk  input  1  sole clock; all logic on its rising edge.
REQ-003 i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_setup  input  30  [23:0] clocks per baud; [29:24] ignored; format fixed at 8N1.
REQ-005 i_uart_rx  input  1  serial line, idle high, asynchronous to i_clk.
REQ-006 o_wr  output  1  one-cycle strobe: o_data holds a valid received byte.
REQ-007 o_data  output  8  last received byte, held until the next o_wr.
REQ-008 o_frame_err  output  1  one-cycle strobe: stop bit sampled low.
REQ-009 o_match  output  1  one-cycle strobe: full 16-byte message received in order.
REQ-010 o_mismatch  output  1  one-cycle strobe: received byte differs from the expected byte.
REQ-011 o_msg_count  output  LGMSGCOUNT  count of o_match pulses, wraps modulo 2^LGMSGCOUNT.
REQ-012 o_break  output  1  line-break indicator (see Configuration).

Function
REQ-013 i_uart_rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-014 Receive FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE->START on a synchronized high-to-low transition; i_setup[23:0] latched and baud counter loaded with half of it.
REQ-016 Latched baud values below 16 SHALL be treated as 16; i_setup changes mid-frame SHALL NOT affect that frame.
REQ-017 START at counter zero: line low -> DATA; line high -> IDLE (false start), no output strobes.
REQ-018 DATA SHALL sample 8 bits LSB first, one full baud apart, at mid-bit, then go to STOP.
REQ-019 STOP at mid-bit: line high -> o_wr pulse next cycle, o_data updated the same cycle, -> IDLE.
REQ-020 STOP at mid-bit: line low -> o_frame_err pulse next cycle, no o_wr, byte discarded, -> WAIT_HIGH.
REQ-021 WAIT_HIGH -> IDLE only after the synchronized line reads high.
REQ-022 Matcher SHALL hold a 4-bit index into the fixed message "Hello, World! \r\n" (16 bytes, index 0 = 'H').
REQ-023 One cycle after o_wr: byte equal to message[index] -> index+1; at index 15, o_match pulses, o_msg_count increments, index -> 0.
REQ-024 One cycle after o_wr: byte unequal -> o_mismatch pulse; index -> 1 if byte is 'H', else 0.
REQ-025 o_frame_err SHALL reset the match index to 0 without an o_mismatch pulse.
REQ-026 o_match and o_mismatch SHALL never assert in the same cycle.

Reset
REQ-027 While i_reset_n is low: FSM = IDLE, synchronizer flops = 1, index = 0, all strobes = 0, o_data = 0, o_msg_count = 0, o_break = 0.
REQ-028 Reset mid-frame SHALL abandon the frame with no strobes; reception resumes on the next falling edge after release.

Configuration
REQ-029 Macro HELLO_RX_BREAK_EN defined: o_break SHALL assert when the synchronized line has been low continuously for more than 10 latched baud periods, and deassert on the first high sample.
REQ-030 While o_break is asserted, no o_wr or o_mismatch SHALL be produced, and the match index SHALL be 0.
REQ-031 Macro undefined: o_break SHALL be tied to 0, and no break counter logic SHALL be instantiated.

Verification
REQ-032 i_setup=868, send "Hello, World! \r\n" twice -> 32 o_wr, 2 o_match, o_msg_count=2, no o_mismatch.
REQ-033 i_setup=868, send "HeXHello, World! \r\n" -> 1 o_mismatch (on 'X'), then 1 o_match.
REQ-034 Send "HH" followed by "ello, World! \r\n" -> 1 o_mismatch on the second 'H', then 1 o_match (resync to index 1).
REQ-035 Send 0x48 with the stop bit low -> o_frame_err=1 for 1 cycle, no o_wr, index=0; the following valid 0x48 produces o_wr with o_data=0x48.
REQ-036 Apply a 300-clock low glitch at i_setup=868 -> no strobes, FSM returns to IDLE; a reset pulse mid-byte then a full message -> exactly 1 o_match.
REQ-037 HELLO_RX_BREAK_EN defined, hold the line low for 12 bauds -> o_break=1 after 10 bauds, clearing when the line goes high; undefined -> o_break stays 0.
